// File: rtl/ux607_expl_axi_mst.sv
// ux607_expl_axi_mst
// Single-outstanding AXI3 burst master. It takes one read or write command
// at a time, runs the address phase, then streams data beats between the
// local rd_*/wd_* ports and the AXI R/W channels. It reports completion with
// a one-cycle done pulse carrying an error flag. The error flag is set by
// SLVERR/DECERR responses and by RLAST that disagrees with the beat count.
module ux607_expl_axi_mst #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    // Command interface
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_read,
    input  logic [AW-1:0]       cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [2:0]          cmd_size,

    // Local write-data stream
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DW-1:0]       wd_data,
    input  logic [DW/8-1:0]     wd_strb,

    // Local read-data stream
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DW-1:0]       rd_data,
    output logic                rd_last,

    // Completion
    output logic                done_valid,
    output logic                done_err,

    // AXI3 read address channel
    output logic                axi_arvalid,
    input  logic                axi_arready,
    output logic [AW-1:0]       axi_araddr,
    output logic [3:0]          axi_arcache,
    output logic [2:0]          axi_arprot,
    output logic [1:0]          axi_arlock,
    output logic [1:0]          axi_arburst,
    output logic [3:0]          axi_arlen,
    output logic [2:0]          axi_arsize,

    // AXI3 write address channel
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [AW-1:0]       axi_awaddr,
    output logic [3:0]          axi_awcache,
    output logic [2:0]          axi_awprot,
    output logic [1:0]          axi_awlock,
    output logic [1:0]          axi_awburst,
    output logic [3:0]          axi_awlen,
    output logic [2:0]          axi_awsize,

    // AXI3 read data channel
    input  logic                axi_rvalid,
    output logic                axi_rready,
    input  logic [DW-1:0]       axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rlast,

    // AXI3 write data channel
    output logic                axi_wvalid,
    input  logic                axi_wready,
    output logic [DW-1:0]       axi_wdata,
    output logic [DW/8-1:0]     axi_wstrb,
    output logic                axi_wlast,

    // AXI3 write response channel
    input  logic                axi_bvalid,
    output logic                axi_bready,
    input  logic [1:0]          axi_bresp
);

    // Largest legal beat size for this data width. Larger requests are
    // clamped so the slave never sees a beat wider than the bus.
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));

    // Constant AXI sideband: INCR bursts, bufferable/modifiable, normal access.
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_VAL  = 4'b0011;
    localparam logic [2:0] PROT_VAL   = 3'b000;
    localparam logic [1:0] LOCK_VAL   = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WADDR = 3'd3,
        S_WDATA = 3'd4,
        S_WRESP = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [AW-1:0]   r_addr;
    logic [3:0]      r_len;
    logic [2:0]      r_size;
    logic            r_read;
    logic [3:0]      r_cnt;
    logic            r_err;

    logic            w_cmd_acc;
    logic            w_last;
    logic            w_r_hs;
    logic            w_w_hs;
    logic            w_b_hs;
    logic [2:0]      w_size_clamped;

    // Beat position and channel handshakes.
    assign w_last    = (r_cnt == r_len);
    assign w_cmd_acc = (r_state == S_IDLE) && cmd_valid;
    assign w_r_hs    = (r_state == S_RDATA) && r_read && axi_rvalid && rd_ready;
    assign w_w_hs    = (r_state == S_WDATA) && wd_valid && axi_wready;
    assign w_b_hs    = (r_state == S_WRESP) && axi_bvalid;

    assign w_size_clamped = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;

    // Address channels always carry the registered command fields; only the
    // valid strobes gate them, so they stay stable until the handshake.
    assign axi_araddr  = r_addr;
    assign axi_arlen   = r_len;
    assign axi_arsize  = r_size;
    assign axi_arburst = BURST_INCR;
    assign axi_arcache = CACHE_VAL;
    assign axi_arprot  = PROT_VAL;
    assign axi_arlock  = LOCK_VAL;

    assign axi_awaddr  = r_addr;
    assign axi_awlen   = r_len;
    assign axi_awsize  = r_size;
    assign axi_awburst = BURST_INCR;
    assign axi_awcache = CACHE_VAL;
    assign axi_awprot  = PROT_VAL;
    assign axi_awlock  = LOCK_VAL;

    // Data buses are pure pass-throughs; qualification lives on valid/ready.
    assign rd_data   = axi_rdata;
    assign axi_wdata = wd_data;
    assign axi_wstrb = wd_strb;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command capture, beat counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_len  <= '0;
            r_size <= '0;
            r_read <= 1'b0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else if (w_cmd_acc) begin
            r_addr <= cmd_addr;
            r_len  <= cmd_len;
            r_size <= w_size_clamped;
            r_read <= cmd_read;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            // The final beat leaves the data state, so holding the counter
            // there keeps it from wrapping on a 16-beat burst.
            if ((w_r_hs || w_w_hs) && !w_last) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_r_hs && (axi_rresp[1] || (axi_rlast != w_last))) begin
                r_err <= 1'b1;
            end
            if (w_b_hs && axi_bresp[1]) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state and per-state handshake outputs.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        axi_arvalid  = 1'b0;
        axi_awvalid  = 1'b0;
        axi_rready   = 1'b0;
        axi_wvalid   = 1'b0;
        axi_wlast    = 1'b0;
        axi_bready   = 1'b0;
        rd_valid     = 1'b0;
        rd_last      = 1'b0;
        wd_ready     = 1'b0;
        done_valid   = 1'b0;
        done_err     = 1'b0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = cmd_read ? S_RADDR : S_WADDR;
                end
            end
            S_RADDR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    w_state_next = S_RDATA;
                end
            end
            S_RDATA: begin
                axi_rready = rd_ready;
                rd_valid   = axi_rvalid;
                rd_last    = w_last;
                // Beat count, not RLAST, decides the end of the burst.
                if (w_r_hs && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_WADDR: begin
                axi_awvalid = 1'b1;
                if (axi_awready) begin
                    w_state_next = S_WDATA;
                end
            end
            S_WDATA: begin
                axi_wvalid = wd_valid;
                wd_ready   = axi_wready;
                axi_wlast  = w_last;
                if (w_w_hs && w_last) begin
                    w_state_next = S_WRESP;
                end
            end
            S_WRESP: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_valid   = 1'b1;
                done_err     = r_err;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ux607_expl_axi_mst.sv
// Directed bench for ux607_expl_axi_mst: a table of read/write bursts with a
// scripted AXI slave, plus hand-written reset-state and mid-burst reset checks.
module tb_ux607_expl_axi_mst;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid, cmd_ready, cmd_read;
    logic [AW-1:0]   cmd_addr;
    logic [3:0]      cmd_len;
    logic [2:0]      cmd_size;
    logic            wd_valid, wd_ready;
    logic [DW-1:0]   wd_data;
    logic [DW/8-1:0] wd_strb;
    logic            rd_valid, rd_ready, rd_last;
    logic [DW-1:0]   rd_data;
    logic            done_valid, done_err;
    logic            axi_arvalid, axi_arready;
    logic [AW-1:0]   axi_araddr;
    logic [3:0]      axi_arcache, axi_arlen;
    logic [2:0]      axi_arprot, axi_arsize;
    logic [1:0]      axi_arlock, axi_arburst;
    logic            axi_awvalid, axi_awready;
    logic [AW-1:0]   axi_awaddr;
    logic [3:0]      axi_awcache, axi_awlen;
    logic [2:0]      axi_awprot, axi_awsize;
    logic [1:0]      axi_awlock, axi_awburst;
    logic            axi_rvalid, axi_rready, axi_rlast;
    logic [DW-1:0]   axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_wvalid, axi_wready, axi_wlast;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_bvalid, axi_bready;
    logic [1:0]      axi_bresp;

    int checks = 0;
    int errors = 0;

    ux607_expl_axi_mst #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_err(done_err),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arlock(axi_arlock),
        .axi_arburst(axi_arburst), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awlock(axi_awlock),
        .axi_awburst(axi_awburst), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [31:0] base;       // data of beat i is base+i
        int          err_beat;   // read beat carrying SLVERR (-1 none)
        int          rlast_beat; // read beat on which the slave raises RLAST
        int          stall_beat; // read beat held off by rd_ready=0 (-1 none)
        int          stall_cyc;
        int          aw_delay;   // cycles before AWREADY
        logic        toggle;     // WREADY alternates low/high
        logic [1:0]  bresp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_done(input logic exp_err);
        #1;
        chk("done_valid", done_valid, 1'b1);
        chk("done_err", done_err, exp_err);
        chk("done_quiet", {axi_rready, axi_bready, axi_wvalid, cmd_ready}, 4'b0000);
        @(negedge clk);
        #1;
        chk("done_pulse_len", done_valid, 1'b0);
        chk("cmd_ready_after", cmd_ready, 1'b1);
    endtask

    task automatic issue_cmd(input vec_t v);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_read  = v.rd;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_size  = v.size;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_read(input vec_t v);
        int  beat;
        int  stall;
        int  guard;
        logic rr;
        issue_cmd(v);
        #1;
        chk("arvalid", axi_arvalid, 1'b1);
        chk("araddr", axi_araddr, v.addr);
        chk("arlen_size", {axi_arlen, axi_arsize}, {v.len, v.size});
        chk("ar_side", {axi_arburst, axi_arcache, axi_arprot, axi_arlock}, {2'b01, 4'b0011, 3'b000, 2'b00});
        chk("busy_idle", {cmd_ready, axi_awvalid, axi_rready}, 3'b000);
        // Hold off ARREADY one cycle: the request must stay put.
        @(negedge clk);
        #1;
        chk("ar_hold", {axi_arvalid, axi_araddr}, {1'b1, v.addr});
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready = 1'b0;
        beat  = 0;
        stall = 0;
        guard = 0;
        while (beat <= int'(v.len) && guard < 100) begin
            rr = !(beat == v.stall_beat && stall < v.stall_cyc);
            rd_ready   = rr;
            axi_rvalid = 1'b1;
            axi_rdata  = v.base + 32'(beat);
            axi_rresp  = (beat == v.err_beat) ? 2'b10 : 2'b00;
            axi_rlast  = (beat == v.rlast_beat);
            #1;
            chk("rready", axi_rready, rr);
            chk("rd_valid", rd_valid, 1'b1);
            chk("rd_data", rd_data, v.base + 32'(beat));
            if (rr) begin
                chk("rd_last", rd_last, beat == int'(v.len));
                beat++;
            end else begin
                stall++;
            end
            @(negedge clk);
            guard++;
        end
        chk("rd_beats", beat, int'(v.len) + 1);
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rresp  = 2'b00;
        rd_ready   = 1'b0;
        check_done(v.exp_err);
    endtask

    task automatic run_write(input vec_t v);
        int   beat;
        int   cyc;
        int   guard;
        logic wr;
        issue_cmd(v);
        wd_valid   = 1'b1;
        wd_data    = v.base;
        wd_strb    = 4'hF;
        axi_wready = 1'b1;
        // Local data is offered early; nothing may reach W before AW completes.
        for (int d = 0; d < v.aw_delay; d++) begin
            #1;
            chk("awvalid_wait", axi_awvalid, 1'b1);
            chk("w_before_aw", {axi_wvalid, wd_ready}, 2'b00);
            @(negedge clk);
        end
        #1;
        chk("awvalid", axi_awvalid, 1'b1);
        chk("awaddr", axi_awaddr, v.addr);
        chk("awlen_size", {axi_awlen, axi_awsize}, {v.len, v.size});
        chk("aw_side", {axi_awburst, axi_awcache, axi_awprot, axi_awlock}, {2'b01, 4'b0011, 3'b000, 2'b00});
        chk("w_at_aw", {axi_wvalid, axi_arvalid}, 2'b00);
        axi_awready = 1'b1;
        @(negedge clk);
        axi_awready = 1'b0;
        beat  = 0;
        cyc   = 0;
        guard = 0;
        while (beat <= int'(v.len) && guard < 100) begin
            wr = v.toggle ? ((cyc % 2) == 1) : 1'b1;
            wd_valid   = 1'b1;
            wd_data    = v.base + 32'(beat);
            wd_strb    = 4'(beat) ^ 4'hA;
            axi_wready = wr;
            #1;
            chk("wvalid", axi_wvalid, 1'b1);
            chk("wdata", axi_wdata, v.base + 32'(beat));
            chk("wstrb", axi_wstrb, 4'(beat) ^ 4'hA);
            chk("wlast", axi_wlast, beat == int'(v.len));
            chk("wd_ready", wd_ready, wr);
            if (wr) beat++;
            cyc++;
            @(negedge clk);
            guard++;
        end
        chk("w_beats", beat, int'(v.len) + 1);
        wd_valid   = 1'b0;
        axi_wready = 1'b0;
        #1;
        chk("bready", {axi_bready, axi_wvalid}, 2'b10);
        axi_bvalid = 1'b1;
        axi_bresp  = v.bresp;
        @(negedge clk);
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        check_done(v.exp_err);
    endtask

    initial begin
        //           rd    addr         len   size  base          err rlast stallB stallC awd tog bresp  exp
        vecs[0] = '{1'b1, 32'h100,    4'd0, 3'd2, 32'hDEADBEEF, -1,  0,   -1,    0,     0, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{1'b0, 32'h2000,   4'd3, 3'd2, 32'hA0000000, -1,  0,   -1,    0,     3, 1'b1, 2'b00, 1'b0};
        vecs[2] = '{1'b1, 32'h300,    4'd1, 3'd2, 32'h11110000,  0,  1,   -1,    0,     0, 1'b0, 2'b00, 1'b1};
        vecs[3] = '{1'b1, 32'h400,    4'd1, 3'd2, 32'h22220000, -1,  1,   -1,    0,     0, 1'b0, 2'b00, 1'b0};
        vecs[4] = '{1'b1, 32'h500,    4'd2, 3'd2, 32'h33330000, -1,  1,   -1,    0,     0, 1'b0, 2'b00, 1'b1};
        vecs[5] = '{1'b1, 32'h600,    4'd3, 3'd2, 32'h44440000, -1,  3,    1,    5,     0, 1'b0, 2'b00, 1'b0};
        vecs[6] = '{1'b0, 32'h700,    4'd1, 3'd2, 32'h55550000, -1,  0,   -1,    0,     0, 1'b0, 2'b10, 1'b1};
        vecs[7] = '{1'b0, 32'h7,      4'd0, 3'd0, 32'h66660000, -1,  0,   -1,    0,     1, 1'b0, 2'b00, 1'b0};
        vecs[8] = '{1'b1, 32'h8000,   4'd15, 3'd2, 32'h77770000, -1, 15,  -1,    0,     0, 1'b0, 2'b00, 1'b0};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rd_ready = 1'b0;
        axi_arready = 1'b0; axi_awready = 1'b0;
        axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
        axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = '0;

        // Reset state, with slave-side inputs active to expose any leakage.
        repeat (2) @(negedge clk);
        axi_rvalid = 1'b1; axi_wready = 1'b1; wd_valid = 1'b1; rd_ready = 1'b1;
        #1;
        chk("rst_valids", {axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready}, 5'b0);
        chk("rst_local", {wd_ready, rd_valid, done_valid}, 3'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_fields", {axi_araddr, axi_arlen, axi_arsize}, 39'h0);
        axi_rvalid = 1'b0; axi_wready = 1'b0; wd_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rd) run_read(vecs[i]);
            else            run_write(vecs[i]);
            $display("vec %0d %s addr=%0h len=%0d checks=%0d errors=%0d",
                     i, vecs[i].rd ? "RD" : "WR", vecs[i].addr, vecs[i].len, checks, errors);
        end

        // Mid-burst reset: write len=3, two beats through, then pull rst_n.
        begin
            vec_t v;
            v = '{1'b0, 32'h900, 4'd3, 3'd2, 32'h99990000, -1, 0, -1, 0, 0, 1'b0, 2'b00, 1'b0};
            issue_cmd(v);
            axi_awready = 1'b1;
            @(negedge clk);
            axi_awready = 1'b0;
            for (int b = 0; b < 2; b++) begin
                wd_valid = 1'b1; wd_data = v.base + 32'(b); wd_strb = 4'hF; axi_wready = 1'b1;
                #1;
                chk("mr_wvalid", axi_wvalid, 1'b1);
                @(negedge clk);
            end
            #1;
            chk("mr_in_wdata", {axi_wvalid, axi_wlast}, 2'b10);
            rst_n = 1'b0;
            axi_bvalid = 1'b1;
            #1;
            chk("mr_valids", {axi_awvalid, axi_wvalid, axi_bready, wd_ready}, 4'b0);
            chk("mr_done", done_valid, 1'b0);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                #1;
                chk("mr_hold", {done_valid, axi_wvalid, cmd_ready}, 3'b001);
            end
            rst_n = 1'b1;
            wd_valid = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
            @(negedge clk);
            #1;
            chk("mr_idle", {cmd_ready, done_valid, axi_awvalid}, 3'b100);
            $display("mid-burst reset checks=%0d errors=%0d", checks, errors);
        end

        // Recovery: a normal read right after the abandoned write.
        run_read(vecs[0]);
        $display("post-reset read checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
